register_file: RTL and testbench

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/register_file.sv | 66 ++++++
 tb/tb_register_file.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// rtl/register_file.sv - two-read one-write register file with optional zero entry 0.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module register_file #(
   parameter int WIDTH   = 32,
   parameter int DEPTH   = 32,
   parameter int ADDR_W  = 5,
   parameter int ZERO_R0 = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              write_n,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic [ADDR_W-1:0] raddr1,
   input  logic [ADDR_W-1:0] raddr2,
   output logic [WIDTH-1:0]  rdata1,
   output logic [WIDTH-1:0]  rdata2
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic             wr_ok;

   always_comb begin
      wr_ok = !write_n && ({1'b0, waddr} < DEPTH_L) &&
              !((ZERO_R0 != 0) && (waddr == '0));
      mem_d = mem_q;
      if (wr_ok) begin
         mem_d[waddr[IDX_W-1:0]] = wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   // Out-of-range and hard-wired-zero addresses read 0; reset forces both ports to 0.
   always_comb begin
      logic [ADDR_W-1:0] ra;
      logic [WIDTH-1:0]  rd [2];
      for (int p = 0; p < 2; p++) begin
         ra    = (p == 0) ? raddr1 : raddr2;
         rd[p] = '0;
         if (!rst && ({1'b0, ra} < DEPTH_L) && !((ZERO_R0 != 0) && (ra == '0))) begin
            rd[p] = mem_q[ra[IDX_W-1:0]];
`ifdef REGFILE_BYPASS_EN
            if (wr_ok && (ra == waddr)) begin
               rd[p] = wdata;
            end
`endif
         end
      end
      rdata1 = rd[0];
      rdata2 = rd[1];
   end

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - self-checking bench for register_file (three parameter sets).
module tb_register_file;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        write_n = 1'b1;
   logic [4:0]  waddr = '0;
   logic [31:0] wdata = '0;
   logic [4:0]  raddr1 = '0;
   logic [4:0]  raddr2 = '0;
   logic [31:0] rd1 [3];
   logic [31:0] rd2 [3];

   int checks = 0;
   int passes = 0;
   bit checking = 1'b0;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   always #5 clk = ~clk;

   // Instance 0: defaults, 1: ZERO_R0=0, 2: DEPTH=16.
   register_file #(.WIDTH(32), .DEPTH(32), .ADDR_W(5), .ZERO_R0(1)) dut (
      .clk(clk), .rst(rst), .write_n(write_n), .waddr(waddr), .wdata(wdata),
      .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1[0]), .rdata2(rd2[0]));
   register_file #(.WIDTH(32), .DEPTH(32), .ADDR_W(5), .ZERO_R0(0)) dut_nz (
      .clk(clk), .rst(rst), .write_n(write_n), .waddr(waddr), .wdata(wdata),
      .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1[1]), .rdata2(rd2[1]));
   register_file #(.WIDTH(32), .DEPTH(16), .ADDR_W(5), .ZERO_R0(1)) dut_d16 (
      .clk(clk), .rst(rst), .write_n(write_n), .waddr(waddr), .wdata(wdata),
      .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1[2]), .rdata2(rd2[2]));

   logic [31:0] model [3][32];

   function automatic int depth_of(input int inst);
      return (inst == 2) ? 16 : 32;
   endfunction

   function automatic bit zr_of(input int inst);
      return inst != 1;
   endfunction

   function automatic bit writable(input int inst, input int a);
      return (a < depth_of(inst)) && !(zr_of(inst) && a == 0);
   endfunction

   function automatic logic [31:0] exp_read(input int inst, input int a);
      if (rst || !writable(inst, a)) return 32'd0;
      if (BYPASS && !write_n && a == int'(waddr)) return wdata;
      return model[inst][a];
   endfunction

   always @(posedge clk or posedge rst) begin
      for (int i = 0; i < 3; i++) begin
         if (rst) begin
            for (int a = 0; a < 32; a++) model[i][a] = 32'd0;
         end else if (!write_n && writable(i, int'(waddr))) begin
            model[i][waddr] = wdata;
         end
      end
   end

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   always @(negedge clk) begin
      if (checking) begin
         for (int i = 0; i < 3; i++) begin
            cmp($sformatf("model_rd1[%0d] a=%0d", i, raddr1), rd1[i], exp_read(i, int'(raddr1)));
            cmp($sformatf("model_rd2[%0d] a=%0d", i, raddr2), rd2[i], exp_read(i, int'(raddr2)));
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      write_n = 1'b0; waddr = a; wdata = d;
      tick();
      write_n = 1'b1; wdata = '0;
   endtask

   initial begin
      tick(); tick();
      rst = 1'b0;
      checking = 1'b1;
      raddr1 = 5'd3; raddr2 = 5'd3;
      #1;
      cmp("reset_rd1_0", rd1[0], 32'd0);

      // Reset then write 123 to entry 3.
      wr(5'd3, 32'd123);
      #1;
      cmp("wr3_rd1", rd1[0], 32'd123);
      cmp("wr3_rd2_same_addr", rd2[0], 32'd123);
      for (int a = 0; a < 32; a++) begin
         if (a != 3) begin
            raddr2 = 5'(a);
            #1;
            cmp($sformatf("others_zero a=%0d", a), rd2[0], 32'd0);
         end
      end

      // Hold for 10 idle edges.
      wr(5'd7, 32'd546);
      raddr1 = 5'd7;
      for (int k = 0; k < 10; k++) tick();
      cmp("hold7", rd1[0], 32'd546);

      // Zero register behaviour.
      wr(5'd0, 32'hFFFF_FFFF);
      raddr1 = 5'd0; raddr2 = 5'd0;
      #1;
      cmp("zr_rd1", rd1[0], 32'd0);
      cmp("zr_rd2", rd2[0], 32'd0);
      cmp("nz_rd1", rd1[1], 32'hFFFF_FFFF);

      // Asynchronous reset mid-cycle.
      wr(5'd1, 32'd5);
      wr(5'd31, 32'd9);
      raddr1 = 5'd1; raddr2 = 5'd31;
      #1;
      cmp("pre_rst_e1", rd1[0], 32'd5);
      cmp("pre_rst_e31", rd2[0], 32'd9);
      rst = 1'b1;
      #1;
      cmp("async_rst_rd1", rd1[0], 32'd0);
      cmp("async_rst_rd2", rd2[0], 32'd0);
      write_n = 1'b0; waddr = 5'd1; wdata = 32'd55;
      tick();
      write_n = 1'b1;
      rst = 1'b0;
      #1;
      cmp("lost_write_in_rst", rd1[0], 32'd0);
      cmp("rst_cleared_e31", rd2[0], 32'd0);
      wr(5'd1, 32'd66);
      #1;
      cmp("first_write_after_rst", rd1[0], 32'd66);

      // Read during write.
      wr(5'd4, 32'd10);
      raddr1 = 5'd4;
      write_n = 1'b0; waddr = 5'd4; wdata = 32'd20;
      #1;
      cmp("rdw_before_edge", rd1[0], BYPASS ? 32'd20 : 32'd10);
      tick();
      write_n = 1'b1;
      #1;
      cmp("rdw_after_edge", rd1[0], 32'd20);

      // Range check on DEPTH=16 instance; 20 must not alias entry 4.
      wr(5'd20, 32'd77);
      raddr1 = 5'd20; raddr2 = 5'd4;
      #1;
      cmp("d16_oor_read", rd1[2], 32'd0);
      cmp("d16_no_alias", rd2[2], 32'd20);
      cmp("d32_wr20", rd1[0], 32'd77);

      // Full width value.
      wr(5'd31, 32'hA5A5_5A5A);
      raddr1 = 5'd31;
      #1;
      cmp("full_width", rd1[0], 32'hA5A5_5A5A);
      tick(); tick();

      checking = 1'b0;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
